multdiv_unit: RTL and testbench
===============================

// Module: multdiv_unit
// PURPOSE
//  Multicycle signed 32-bit multiply/divide unit in the execute stage, beside the single-cycle ALU.
//  Takes the same operand A/B as the ALU (and/or/not/add/shift) and returns result + exception.
//  The core's execute-stage mux selects this result; the pipeline stalls until data_resultRDY.
// PARAMETERS
//  WIDTH    32  operand/result width (design and test at 32 only)
//  COUNT_W  6   iteration counter width, must hold WIDTH+1
// PORTS
//  clock           in   1      core clock, rising edge
//  reset           in   1      synchronous, active-high
//  ctrl_MULT       in   1      start signed multiply (sampled every edge)
//  ctrl_DIV        in   1      start signed divide (sampled every edge)
//  data_operandA   in   WIDTH  multiplicand / dividend, captured at start edge only
//  data_operandB   in   WIDTH  multiplier / divisor, captured at start edge only
//  data_result     out  WIDTH  low WIDTH bits of product, or quotient
//  data_exception  out  1      overflow / divide-by-zero flag, valid with data_resultRDY
//  data_resultRDY  out  1      one-cycle pulse: result and exception valid
// BEHAVIOUR
//  Reset: state IDLE, data_result=0, data_exception=0, data_resultRDY=0, counter=0.
//  Reset mid-operation aborts with no RDY pulse; outputs return to 0.
//  States: IDLE -> MULT|DIV (on start) -> DONE (counter==WIDTH) -> IDLE.
//  Start = ctrl_MULT|ctrl_DIV at a rising edge, in any state; operands latched at that edge.
//  Both ctrl high in the same cycle: MULT wins.
//  Start while MULT/DIV/DONE: current op abandoned without RDY; restarts with new operands.
//  MULT: shift-add on magnitudes; one iteration per cycle, WIDTH iterations.
//   Sign applied at the end. Result = product[WIDTH-1:0].
//   Exception=1 iff the 2*WIDTH signed product is not the sign extension of its low WIDTH bits.
//  DIV: restoring division on magnitudes; WIDTH iterations; quotient truncates toward zero.
//   Remainder is discarded.
//   Divisor 0: result=0, exception=1.
//   0x80000000 / -1: result=0x80000000, exception=1.
//  Latency: start edge = E0; iterations E1..E32; RDY high in the cycle after E33.
//   That is 33 cycles from start.
//  RDY is high for exactly one cycle. data_result/data_exception then hold until the next start or reset.
//  A start edge clears data_exception to 0; data_result holds its old value until DONE.
//  Operand inputs changing after E0 have no effect.
// CONFIGURATION
//  MULTDIV_EARLY_OUT_EN defined: trivial cases go from IDLE straight to DONE at E0.
//   RDY then pulses in the cycle after E1.
//   Trivial cases: MULT with either operand 0 (result 0, exc 0); DIV with divisor 0 (result 0, exc 1).
//  Not defined: every operation takes the full 33-cycle latency; results are identical.
// TESTING
//  1 ctrl_MULT, A=6, B=7 -> RDY at cycle 33 only; result=42, exc=0.
//  2 ctrl_MULT, A=-7, B=3 -> result=0xFFFFFFEB (-21), exc=0.
//    A=0x00010000, B=0x00010000 -> result=0, exc=1.
//  3 ctrl_DIV, A=100, B=-7 -> result=-14 (0xFFFFFFF2), exc=0.
//    A=-100, B=7 -> -14.
//    A=0x80000000, B=-1 -> 0x80000000, exc=1.
//  4 ctrl_DIV, A=5, B=0 -> result=0, exc=1.
//    RDY at cycle 33 without the macro; at cycle 1 with MULTDIV_EARLY_OUT_EN.
//  5 MULT 6*7 started; reset at cycle 10 -> no RDY; outputs 0.
//    Then DIV 9/3 -> result=3 at cycle 33.
//  6 MULT 6*7 started; ctrl_DIV with 20/4 at cycle 5 -> single RDY at cycle 38; result=5.
//    Both ctrl high with A=2, B=3 -> result=6 (MULT).

Source files
------------

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply/divide unit: shift-add multiply and restoring divide on magnitudes.
// Optional MULTDIV_EARLY_OUT_EN: trivial operands skip the iterations and finish in one cycle.
module multdiv_unit #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 neg_q, neg_d;
  logic                 div_q, div_d;
  logic                 triv_q, triv_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 exc_q, exc_d;
  logic                 rdy_q, rdy_d;

  logic                 start;
  logic                 triv_start;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH-1:0]   mult_next;
  logic [WIDTH:0]       rem_sh, diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_s;
  logic                 mult_exc;
  logic [WIDTH-1:0]     quo_s;

  assign start = ctrl_MULT | ctrl_DIV;
  assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_EARLY_OUT_EN
  assign triv_start = ctrl_MULT ? ((data_operandA == '0) || (data_operandB == '0))
                                : (data_operandB == '0);
`else
  assign triv_start = 1'b0;
`endif

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mult_next = {add_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits becoming quotient bits}, shifted left each step.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, opb_q};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  assign prod_s   = neg_q ? -acc_q : acc_q;
  assign mult_exc = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));
  assign quo_s    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    div_d    = div_q;
    triv_d   = triv_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (start) begin
      // A new start abandons whatever is in flight; MULT has priority over DIV.
      div_d   = ~ctrl_MULT;
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      opb_d   = ctrl_MULT ? mag_a : mag_b;
      acc_d   = {{WIDTH{1'b0}}, (ctrl_MULT ? mag_b : mag_a)};
      cnt_d   = '0;
      exc_d   = 1'b0;
      triv_d  = triv_start;
      state_d = triv_start ? S_DONE : (ctrl_MULT ? S_MULT : S_DIV);
    end else begin
      unique case (state_q)
        S_MULT, S_DIV: begin
          acc_d = (state_q == S_DIV) ? div_next : mult_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == COUNT_W'(WIDTH - 1)) state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
          if (triv_q) begin
            result_d = '0;
            exc_d    = div_q;
          end else if (div_q) begin
            if (opb_q == '0) begin
              result_d = '0;
              exc_d    = 1'b1;
            end else begin
              // Only a positive quotient of 2^(WIDTH-1) cannot be represented.
              result_d = quo_s;
              exc_d    = ~neg_q & acc_q[WIDTH-1];
            end
          end else begin
            result_d = prod_s[WIDTH-1:0];
            exc_d    = mult_exc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  // NOTE: datapath registers need no reset; they are always loaded at a start edge before use.
  always_ff @(posedge clock) begin
    acc_q  <= acc_d;
    opb_q  <= opb_d;
    neg_q  <= neg_d;
    div_q  <= div_d;
    triv_q <= triv_d;
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: scoreboard of expected result/exception/ready-cycle,
// popped by a monitor on every ready pulse.
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  multdiv_unit #(.WIDTH(32), .COUNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

`ifdef MULTDIV_EARLY_OUT_EN
  localparam int LAT_TRIV = 1;
`else
  localparam int LAT_TRIV = 33;
`endif
  localparam int LAT_FULL = 33;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        check("spurious_rdy", 64'(data_resultRDY), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", 64'(data_result), 64'(mon_e.res));
        check("exception", 64'(data_exception), 64'(mon_e.exc));
        check("rdy_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Independent reference: full-width signed arithmetic.
  function automatic logic [32:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_, p;
    logic [31:0] q;
    if (m) begin
      sa = {{32{a[31]}}, a};
      sb_ = {{32{b[31]}}, b};
      p  = sa * sb_;
      return {(p != {{32{p[31]}}, p[31:0]}), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  function automatic int lat_of(input logic m, input logic [31:0] a, input logic [31:0] b);
    if (m ? (a == 0 || b == 0) : (b == 0)) return LAT_TRIV;
    return LAT_FULL;
  endfunction

  task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, output int c0);
    @(negedge clock);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    c0 = cyc;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clock);
    check("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic run(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic exc, input int lat);
    int c0;
    start_op(m, d, a, b, c0);
    sb.push_back('{res: res, exc: exc, cyc: c0 + lat});
    wait_drain();
  endtask

  task automatic run_model(input logic m, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    r = model(m, a, b);
    run(m, ~m, a, b, r[31:0], r[32], lat_of(m, a, b));
  endtask

  initial begin
    int c0, c1;
    logic m;
    logic [31:0] a, b;

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    run(1, 0, 32'd6, 32'd7, 32'd42, 1'b0, LAT_FULL);
    run(1, 0, -32'sd7, 32'd3, 32'hFFFF_FFEB, 1'b0, LAT_FULL);
    run(1, 0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, LAT_FULL);
    run(0, 1, 32'd100, -32'sd7, 32'hFFFF_FFF2, 1'b0, LAT_FULL);
    run(0, 1, -32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b0, LAT_FULL);
    run(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, LAT_FULL);
    run(0, 1, 32'd5, 32'd0, 32'd0, 1'b1, LAT_TRIV);

    // A start clears the exception immediately but leaves the old result in place.
    start_op(1, 0, 32'd6, 32'd7, c0);
    check("start_clears_exc", 64'(data_exception), 64'd0);
    check("result_held_busy", 64'(data_result), 64'd0);
    sb.push_back('{res: 32'd42, exc: 1'b0, cyc: c0 + LAT_FULL});
    wait_drain();
    repeat (3) @(negedge clock);
    check("result_held_idle", 64'(data_result), 64'd42);

    // Restart mid-operation: only the second op reports, 38 cycles after the first start.
    start_op(1, 0, 32'd6, 32'd7, c0);
    repeat (4) @(negedge clock);
    start_op(0, 1, 32'd20, 32'd4, c1);
    sb.push_back('{res: 32'd5, exc: 1'b0, cyc: c0 + 38});
    wait_drain();

    run(1, 1, 32'd2, 32'd3, 32'd6, 1'b0, LAT_FULL);

    // Reset at cycle 10 aborts the multiply with no ready pulse.
    start_op(1, 0, 32'd6, 32'd7, c0);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_result", 64'(data_result), 64'd0);
    check("abort_exc", 64'(data_exception), 64'd0);
    check("abort_rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    run(0, 1, 32'd9, 32'd3, 32'd3, 1'b0, LAT_FULL);

    run_model(1, 32'd0, 32'd12345);
    run_model(1, -32'sd5, 32'd0);
    run_model(1, 32'h8000_0000, 32'h8000_0000);
    run_model(1, 32'hFFFF_FFFF, 32'h8000_0000);
    run_model(1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    run_model(0, 32'h7FFF_FFFF, 32'd1);
    run_model(0, 32'h8000_0000, 32'd2);
    run_model(0, 32'd3, 32'd7);

    for (int i = 0; i < 16; i++) begin
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($signed(32'($urandom_range(0, 200))) - 100) : $urandom;
      if (i % 4 == 1) a = 32'($urandom_range(0, 70000));
      run_model(m, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
